// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle for the hazard controller: stage register
// indices and control bits in, stall/flush/forward/mul-div controls out.
interface hazard_controller_if;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic       ResultSrcE0;
  logic       PCSrcE;
  logic       MulDivE;

  logic       StallF, StallD, FlushD;
  logic       StallE, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       DivStart, DivBusy;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE,
    input  StallF, StallD, FlushD, StallE, FlushE, FlushM,
    input  ForwardAE, ForwardBE, DivStart, DivBusy
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE,
    output StallF, StallD, FlushD, StallE, FlushE, FlushM,
    output ForwardAE, ForwardBE, DivStart, DivBusy
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use and
// branch stall/flush, and a mul/div sequencer that freezes F/D/E during long ops.
module hazard_controller #(
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned CNT_W       = 8
) (
  input logic                clk,
  input logic                reset,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;

  logic       lw_stall;
  logic       div_start;
  logic       div_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // DONE ignores MulDivE: the finished op is still sitting in EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.MulDivE) begin
            state  <= BUSY;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state  <= DONE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    lw_stall  = hz.ResultSrcE0 && (hz.RdE != '0) &&
                ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    div_start = (state == IDLE) && hz.MulDivE;
    div_stall = div_start || (state == BUSY);
  end

  // Memory stage has priority over writeback; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && (hz.RdM == hz.Rs1E) && (hz.Rs1E != '0))
      fwd_a = 2'b10;
    else if (hz.RegWriteW && (hz.RdW == hz.Rs1E) && (hz.Rs1E != '0))
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.RdM == hz.Rs2E) && (hz.Rs2E != '0))
      fwd_b = 2'b10;
    else if (hz.RegWriteW && (hz.RdW == hz.Rs2E) && (hz.Rs2E != '0))
      fwd_b = 2'b01;
  end

  assign hz.StallF    = !reset && (lw_stall || div_stall);
  assign hz.StallD    = !reset && (lw_stall || div_stall);
  assign hz.StallE    = !reset && div_stall;
  assign hz.FlushM    = !reset && div_stall;
  assign hz.FlushD    = !reset && hz.PCSrcE;
  assign hz.FlushE    = !reset && (lw_stall || hz.PCSrcE);
  assign hz.ForwardAE = reset ? 2'b00 : fwd_a;
  assign hz.ForwardBE = reset ? 2'b00 : fwd_b;
  assign hz.DivStart  = !reset && div_start;
  assign hz.DivBusy   = !reset && busy_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed test-plan steps followed
// by constrained-random cycles compared against a timeline model of the pipeline.
module tb_hazard_controller;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_controller_if hz ();

  hazard_controller #(.DIV_LATENCY(L), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  // Position of the current long op in its timeline: 0 = start cycle,
  // 1..L-1 = busy cycles, L = done cycle; -1 = no op in flight.
  int age    = -1;
  int starts[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
    if (rs == 5'd0)          return 2'b00;
    if (wm && rdm == rs)     return 2'b10;
    if (ww && rdw == rs)     return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0; hz.MulDivE = 1'b0;
  endtask

  // Called just after a negedge with inputs applied; checks every output
  // against the model, advances one clock, returns at the following negedge.
  task automatic step();
    int   active;
    logic r, lw, dv;
    #2;
    r      = reset;
    active = (age >= 0) ? age : (hz.MulDivE ? 0 : -1);
    dv     = !r && (active >= 0) && (active < L);
    lw     = !r && hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
             ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    chk1("StallF", hz.StallF, lw | dv);
    chk1("StallD", hz.StallD, lw | dv);
    chk1("StallE", hz.StallE, dv);
    chk1("FlushM", hz.FlushM, dv);
    chk1("FlushD", hz.FlushD, !r && hz.PCSrcE);
    chk1("FlushE", hz.FlushE, !r && (lw || hz.PCSrcE));
    chk1("DivStart", hz.DivStart, !r && (active == 0));
    chk1("DivBusy", hz.DivBusy, !r && (active >= 1) && (active < L));
    chk2("ForwardAE", hz.ForwardAE,
         r ? 2'b00 : fwd_ref(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW));
    chk2("ForwardBE", hz.ForwardBE,
         r ? 2'b00 : fwd_ref(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW));
    if (hz.DivStart === 1'b1) starts.push_back(cyc);
    @(posedge clk);
    cyc++;
    if (r)                            age = -1;
    else if (active >= 0 && active < L) age = active + 1;
    else                              age = -1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);

    // Reset: outputs forced low despite hazard-provoking inputs.
    hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.MulDivE = 1'b1;
    #1;
    chk1("rst_StallF", hz.StallF, 1'b0);
    chk2("rst_FwdA", hz.ForwardAE, 2'b00);
    chk1("rst_DivStart", hz.DivStart, 1'b0);
    step();
    step();
    reset = 1'b0;
    clear_inputs();
    step();

    // Forwarding priority.
    hz.RdM = 5'd5; hz.RdW = 5'd5; hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
    #1;
    chk2("fwdA_M", hz.ForwardAE, 2'b10);
    chk2("fwdB_M", hz.ForwardBE, 2'b10);
    step();
    hz.RegWriteM = 1'b0;
    #1;
    chk2("fwdA_W", hz.ForwardAE, 2'b01);
    step();
    hz.Rs1E = 5'd0;
    #1;
    chk2("fwdA_x0", hz.ForwardAE, 2'b00);
    step();
    clear_inputs();

    // Load-use.
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1;
    chk1("lu_StallF", hz.StallF, 1'b1);
    chk1("lu_StallD", hz.StallD, 1'b1);
    chk1("lu_FlushE", hz.FlushE, 1'b1);
    chk1("lu_FlushD", hz.FlushD, 1'b0);
    chk1("lu_StallE", hz.StallE, 1'b0);
    step();
    clear_inputs();
    step();
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd0; hz.Rs2D = 5'd0;
    #1;
    chk1("lu_x0_StallF", hz.StallF, 1'b0);
    step();
    clear_inputs();

    // Taken branch.
    hz.PCSrcE = 1'b1;
    #1;
    chk1("br_FlushD", hz.FlushD, 1'b1);
    chk1("br_FlushE", hz.FlushE, 1'b1);
    chk1("br_StallF", hz.StallF, 1'b0);
    step();
    clear_inputs();
    step();

    // Long ops held back-to-back: start, L stall cycles, one DONE cycle, repeat.
    starts.delete();
    hz.MulDivE = 1'b1;
    for (int k = 0; k < 2 * (L + 1); k++) begin
      #1;
      chk1("md_DivStart", hz.DivStart, (k % (L + 1)) == 0);
      chk1("md_StallF", hz.StallF, (k % (L + 1)) < L);
      chk1("md_FlushM", hz.FlushM, (k % (L + 1)) < L);
      step();
    end
    hz.MulDivE = 1'b0;
    step();
    chk_int("md_start_count", starts.size(), 2);
    if (starts.size() == 2)
      chk_int("md_start_spacing", starts[1] - starts[0], L + 1);

    // Reset in the second BUSY cycle aborts the op.
    hz.MulDivE = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hz.MulDivE = 1'b0;
    #1;
    chk1("abort_DivBusy", hz.DivBusy, 1'b0);
    chk1("abort_StallF", hz.StallF, 1'b0);
    chk1("abort_DivStart", hz.DivStart, 1'b0);
    step();
    step();

    // Constrained-random traffic.
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
      hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
      hz.RdE  = 5'($urandom_range(0, 7));
      hz.RdM  = 5'($urandom_range(0, 7)); hz.RdW = 5'($urandom_range(0, 7));
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      if (age >= 0 && age < L) begin
        hz.MulDivE = 1'b1; hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0;
      end else if (age == L) begin
        hz.MulDivE = 1'($urandom_range(0, 1));
        hz.ResultSrcE0 = 1'($urandom_range(0, 1));
        hz.PCSrcE = hz.ResultSrcE0 ? 1'b0 : 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 7) == 0) begin
        hz.MulDivE = 1'b1; hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0;
      end else begin
        hz.MulDivE = 1'b0;
        hz.ResultSrcE0 = 1'($urandom_range(0, 1));
        hz.PCSrcE = hz.ResultSrcE0 ? 1'b0 : 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end
endmodule
